// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the memory stage
// and the data memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder: one outstanding load/store, fixed wait
// states, byte-lane stores, full-word load responses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        rvld_q, rvld_d;
  logic        rerr_q, rerr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [2:0]    c_f3;
  logic          is_b, is_h, is_w;
  logic          bad_f3, misal, oor, err;
  logic [AW-1:0] idx;
  logic [31:0]   old_w, wd, merged;
  logic [3:0]    be;
  logic          go;
  logic          wr_en;

  // With no wait states the response is built from the live request.
  assign c_we    = (state_q == IDLE) ? bus.req_we     : we_q;
  assign c_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
  assign c_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
  assign c_f3    = (state_q == IDLE) ? bus.req_funct3 : f3_q;

  assign is_b   = (c_f3 == 3'b000) || (c_f3 == 3'b100);
  assign is_h   = (c_f3 == 3'b001) || (c_f3 == 3'b101);
  assign is_w   = (c_f3 == 3'b010);
  assign bad_f3 = !(is_b || is_h || is_w) || (c_we && c_f3[2]);
  assign misal  = (is_h && c_addr[0]) ||
                  (is_w && (c_addr[1:0] != 2'b00));
  assign oor    = c_addr[31:2] >= 30'(DEPTH_WORDS);
  assign err    = bad_f3 || misal || oor;

  assign idx   = c_addr[AW+1:2];
  assign old_w = mem_q[idx];

  always_comb begin
    be = 4'b0000;
    wd = c_wdata;
    unique case (1'b1)
      is_b: begin
        be = 4'b0001 << c_addr[1:0];
        wd = {4{c_wdata[7:0]}};
      end
      is_h: begin
        be = c_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{c_wdata[15:0]}};
      end
      is_w: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    merged = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rvld_d  = rvld_q;
    rerr_d  = rerr_q;
    rdata_d = rdata_q;
    go      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          f3_d    = bus.req_funct3;
          cnt_d   = 4'd0;
          if (WAIT_CYCLES == 0) go = 1'b1;
          else state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'(WAIT_CYCLES - 1)) go = 1'b1;
        else cnt_d = cnt_q + 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rvld_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go) begin
      state_d = RESP;
      rvld_d  = 1'b1;
      rerr_d  = err;
      rdata_d = err ? 32'd0 : (c_we ? merged : old_w);
    end
  end

  assign wr_en = go && c_we && !err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      rvld_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rvld_q  <= rvld_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem_q[idx] <= merged;
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rvld_q;
  assign bus.rsp_err   = rerr_q;
  assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic
// against a byte-level memory model, on three wait-state settings.
module tb_dmem_responder;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] mdl [3][DEPTH];

  dmem_responder_if b1 ();
  dmem_responder_if b3 ();
  dmem_responder_if b0 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .bus(b1));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .bus(b3));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(bit we, logic [31:0] a, logic [2:0] f3);
    int sz;
    if (f3 == 3 || f3 >= 6) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    sz = 1 << f3[1:0];
    if (a % sz != 0) return 1'b1;
    if (a / 4 >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_store(int k, logic [31:0] a, logic [2:0] f3,
                         logic [31:0] wd);
    int sz, lane;
    sz = 1 << f3[1:0];
    for (int j = 0; j < sz; j++) begin
      lane = a % 4 + j;
      mdl[k][a[5:2]][8*lane +: 8] = wd[8*j +: 8];
    end
  endtask

  task automatic xact(virtual dmem_responder_if v, int k, int wc,
                      bit we, logic [31:0] a, logic [31:0] wd,
                      logic [2:0] f3, int hold);
    logic [31:0] exp_d;
    bit exp_e;
    int n;
    exp_e = m_err(we, a, f3);
    if (!exp_e && we) m_store(k, a, f3, wd);
    exp_d = exp_e ? 32'd0 : mdl[k][a[5:2]];
    @(negedge clk);
    chk("req_ready_idle", 32'(v.req_ready), 32'd1);
    v.req_valid  = 1'b1;
    v.req_we     = we;
    v.req_addr   = a;
    v.req_wdata  = wd;
    v.req_funct3 = f3;
    @(posedge clk);
    @(negedge clk);
    v.req_valid  = 1'b0;
    v.req_we     = ~we;
    v.req_addr   = $urandom;
    v.req_wdata  = $urandom;
    v.req_funct3 = 3'($urandom);
    n = 1;
    while (!v.rsp_valid && n <= 20) begin
      chk("req_ready_wait", 32'(v.req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(wc + 1));
    chk("rdata", v.rsp_rdata, exp_d);
    chk("err", 32'(v.rsp_err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(v.rsp_valid), 32'd1);
      chk("hold_rdata", v.rsp_rdata, exp_d);
      chk("hold_err", 32'(v.rsp_err), 32'(exp_e));
      chk("hold_ready", 32'(v.req_ready), 32'd0);
    end
    v.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v.rsp_ready = 1'b0;
    chk("ready_after", 32'(v.req_ready), 32'd1);
    chk("valid_after", 32'(v.rsp_valid), 32'd0);
  endtask

  task automatic idle_bus(virtual dmem_responder_if v);
    v.req_valid  = 1'b0;
    v.req_we     = 1'b0;
    v.req_addr   = 32'd0;
    v.req_wdata  = 32'd0;
    v.req_funct3 = 3'd0;
    v.rsp_ready  = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    checks = 0;
    errors = 0;
    idle_bus(b1);
    idle_bus(b3);
    idle_bus(b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(b1.rsp_valid), 32'd0);
    chk("rst_err", 32'(b1.rsp_err), 32'd0);
    chk("rst_rdata", b1.rsp_rdata, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(b1.req_ready), 32'd1);

    for (int w = 0; w < DEPTH; w++)
      xact(b1, 0, 1, 1'b1, 32'(w * 4), $urandom, 3'b010, 0);

    // Basic word store/load, then byte and half stores into it.
    xact(b1, 0, 1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
    xact(b1, 0, 1, 1'b0, 32'h10, 32'h0, 3'b010, 0);
    xact(b1, 0, 1, 1'b1, 32'h11, 32'h000000AA, 3'b000, 0);
    xact(b1, 0, 1, 1'b0, 32'h10, 32'h0, 3'b010, 0);
    chk("sb_word", mdl[0][4], 32'hDEADAAEF);
    xact(b1, 0, 1, 1'b1, 32'h12, 32'h00001234, 3'b001, 0);
    xact(b1, 0, 1, 1'b0, 32'h10, 32'h0, 3'b010, 0);

    // Rejected requests leave the array alone.
    xact(b1, 0, 1, 1'b1, 32'h13, 32'h11223344, 3'b010, 0);
    xact(b1, 0, 1, 1'b0, 32'h01, 32'h0, 3'b001, 0);
    xact(b1, 0, 1, 1'b0, 32'h10, 32'h0, 3'b011, 0);
    xact(b1, 0, 1, 1'b0, 32'(DEPTH * 4), 32'h0, 3'b010, 0);
    xact(b1, 0, 1, 1'b1, 32'(DEPTH * 4), 32'h5, 3'b010, 0);
    xact(b1, 0, 1, 1'b1, 32'h10, 32'h77, 3'b100, 0);
    xact(b1, 0, 1, 1'b0, 32'h10, 32'h0, 3'b010, 0);
    xact(b1, 0, 1, 1'b0, 32'h14, 32'h0, 3'b010, 5);

    for (int t = 0; t < 80; t++) begin
      a = 32'($urandom_range(0, DEPTH * 4 + 15));
      if ($urandom_range(0, 9) == 0) a = a | 32'h8000_0000;
      xact(b1, 0, 1, 1'($urandom), a, $urandom,
           3'($urandom), $urandom_range(0, 2));
    end

    // Reset while the response is held: write stays, response drops.
    @(negedge clk);
    b1.req_valid  = 1'b1;
    b1.req_we     = 1'b1;
    b1.req_addr   = 32'h8;
    b1.req_wdata  = 32'hCAFEF00D;
    b1.req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    b1.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("resp_pre_rst", 32'(b1.rsp_valid), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("resp_rst_valid", 32'(b1.rsp_valid), 32'd0);
    chk("resp_rst_rdata", b1.rsp_rdata, 32'd0);
    chk("resp_rst_ready", 32'(b1.req_ready), 32'd1);
    mdl[0][2] = 32'hCAFEF00D;
    xact(b1, 0, 1, 1'b0, 32'h8, 32'h0, 3'b010, 0);

    // Three wait states, with a reset that aborts a store.
    xact(b3, 1, 3, 1'b1, 32'h20, 32'h11111111, 3'b010, 0);
    xact(b3, 1, 3, 1'b0, 32'h20, 32'h0, 3'b010, 1);
    @(negedge clk);
    b3.req_valid  = 1'b1;
    b3.req_we     = 1'b1;
    b3.req_addr   = 32'h20;
    b3.req_wdata  = 32'h55;
    b3.req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    b3.req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("wait_rst_ready", 32'(b3.req_ready), 32'd1);
    chk("wait_rst_valid", 32'(b3.rsp_valid), 32'd0);
    repeat (4) @(posedge clk);
    xact(b3, 1, 3, 1'b0, 32'h20, 32'h0, 3'b010, 0);

    // No wait states: response on the cycle after accept.
    xact(b0, 2, 0, 1'b1, 32'h4, 32'h8899AABB, 3'b010, 0);
    xact(b0, 2, 0, 1'b0, 32'h5, 32'h0, 3'b100, 2);
    xact(b0, 2, 0, 1'b1, 32'h6, 32'hFFFF0102, 3'b001, 0);
    xact(b0, 2, 0, 1'b0, 32'h4, 32'h0, 3'b010, 0);
    xact(b0, 2, 0, 1'b0, 32'h3, 32'h0, 3'b101, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
